// File: rtl/soc_mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store; data port has priority.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module soc_mem_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   // state     | meaning
   // OWN_NONE  | no access issued last cycle, no read data returning
   // OWN_INST  | fetch granted last cycle, mem_rdata belongs to the fetch port
   // OWN_DATA  | load/store granted last cycle, rvalid goes to the data port
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_INST = 2'd1;
   localparam logic [1:0] OWN_DATA = 2'd2;

   logic [1:0] owner;
   logic       gnt_i;
   logic       gnt_d;
   logic       starve;

`ifdef ARB_STARVE_GUARD_EN
   localparam int WAIT_W = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;

   logic [WAIT_W-1:0] wait_cnt;

   assign starve = (wait_cnt >= WAIT_W'(MAX_WAIT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (!i_req || gnt_i) begin
         wait_cnt <= '0;
      end else if (wait_cnt != '1) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end
`else
   assign starve = 1'b0;
`endif

   // Grants are held off while rst is high so nothing reaches the RAM during reset.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (!rst) begin
         if (d_req && !(i_req && starve)) begin
            gnt_d = 1'b1;
         end else if (i_req) begin
            gnt_i = 1'b1;
         end
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_we    = 4'b0000;
      mem_wdata = '0;
      if (gnt_d) begin
         mem_addr = d_addr[ADDR_W+1:2];
         if (d_we) begin
            mem_we    = d_be;
            mem_wdata = d_wdata;
         end
      end else if (gnt_i) begin
         mem_addr = i_addr[ADDR_W+1:2];
      end
   end

   assign i_gnt  = gnt_i;
   assign d_gnt  = gnt_d;
   assign mem_en = gnt_i | gnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner <= OWN_NONE;
      end else if (gnt_d) begin
         owner <= OWN_DATA;
      end else if (gnt_i) begin
         owner <= OWN_INST;
      end else begin
         owner <= OWN_NONE;
      end
   end

   assign i_rvalid = (owner == OWN_INST);
   assign d_rvalid = (owner == OWN_DATA);
   assign i_rdata  = i_rvalid ? mem_rdata : '0;
   assign d_rdata  = d_rvalid ? mem_rdata : '0;

   // Byte-offset and out-of-range address bits are intentionally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                               d_addr[31:ADDR_W+2], d_addr[1:0]};

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Directed bench for soc_mem_arbiter with a behavioural RAM and an rvalid scoreboard.
module tb_soc_mem_arbiter;
   localparam int ADDR_W   = 12;
   localparam int MAX_WAIT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_req;
   logic [31:0]       i_addr;
   logic              i_gnt, i_rvalid;
   logic [31:0]       i_rdata;
   logic              d_req, d_we;
   logic [3:0]        d_be;
   logic [31:0]       d_addr, d_wdata;
   logic              d_gnt, d_rvalid;
   logic [31:0]       d_rdata;
   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   logic [31:0] ram [0:(1<<ADDR_W)-1];

   typedef struct {
      bit          is_data;
      bit          chk_data;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   soc_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM with byte writes and registered read.
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= ram[mem_addr];
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit is_data, input bit chk_data, input logic [31:0] data);
      exp_t e;
      e.is_data  = is_data;
      e.chk_data = chk_data;
      e.data     = data;
      sb.push_back(e);
   endtask

   // Advance one clock and score whatever rvalid the previous cycle's grant produced.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("i_rvalid", {31'b0, i_rvalid}, {31'b0, !e.is_data});
         chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, e.is_data});
         if (e.chk_data) begin
            if (e.is_data) chk("d_rdata", d_rdata, e.data);
            else           chk("i_rdata", i_rdata, e.data);
         end
      end else begin
         chk("idle_i_rvalid", {31'b0, i_rvalid}, 32'd0);
         chk("idle_d_rvalid", {31'b0, d_rvalid}, 32'd0);
      end
   endtask

   initial begin
      int w;
      bit exp_i;

      for (int k = 0; k < (1 << ADDR_W); k++) ram[k] = 32'hA000_0000 + k;
      ram[4] = 32'h0000_0013;
      ram[8] = 32'h1122_3344;
      mem_rdata = '0;

      // Reset held with both requesters active.
      rst = 1'b1; i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b0;
      d_be = 4'hF; d_addr = 32'h40; d_wdata = '0;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("rst_i_gnt",    {31'b0, i_gnt},    32'd0);
         chk("rst_d_gnt",    {31'b0, d_gnt},    32'd0);
         chk("rst_mem_en",   {31'b0, mem_en},   32'd0);
         chk("rst_mem_we",   {28'b0, mem_we},   32'd0);
         chk("rst_i_rvalid", {31'b0, i_rvalid}, 32'd0);
         chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
         chk("rst_i_rdata",  i_rdata, 32'd0);
         chk("rst_d_rdata",  d_rdata, 32'd0);
      end

      // Release: data wins the conflict first, fetch follows next cycle.
      rst = 1'b0;
      #1;
      chk("conf_d_gnt",   {31'b0, d_gnt}, 32'd1);
      chk("conf_i_gnt",   {31'b0, i_gnt}, 32'd0);
      chk("conf_d_addr",  {20'b0, mem_addr}, 32'd16);
      push(1'b1, 1'b1, 32'hA000_0010);
      tick();
      d_req = 1'b0;
      #1;
      chk("conf2_i_gnt",  {31'b0, i_gnt}, 32'd1);
      chk("conf2_d_gnt",  {31'b0, d_gnt}, 32'd0);
      chk("conf2_addr",   {20'b0, mem_addr}, 32'd17);
      push(1'b0, 1'b1, 32'hA000_0011);
      tick();
      i_req = 1'b0;
      #1;
      chk("idle_mem_en",  {31'b0, mem_en}, 32'd0);
      chk("idle_mem_we",  {28'b0, mem_we}, 32'd0);
      tick();

      // Lone fetch.
      i_req = 1'b1; i_addr = 32'h0000_0010;
      #1;
      chk("fetch_i_gnt",  {31'b0, i_gnt}, 32'd1);
      chk("fetch_addr",   {20'b0, mem_addr}, 32'd4);
      chk("fetch_we",     {28'b0, mem_we}, 32'd0);
      push(1'b0, 1'b1, 32'h0000_0013);
      tick();
      i_req = 1'b0;

      // Partial store followed back-to-back by a load of the same word.
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
      #1;
      chk("st_d_gnt",     {31'b0, d_gnt}, 32'd1);
      chk("st_mem_we",    {28'b0, mem_we}, 32'h3);
      chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st_addr",      {20'b0, mem_addr}, 32'd8);
      push(1'b1, 1'b0, 32'h0);
      tick();
      d_we = 1'b0; d_addr = 32'h22;
      #1;
      chk("ld_d_gnt",     {31'b0, d_gnt}, 32'd1);
      chk("ld_mem_we",    {28'b0, mem_we}, 32'd0);
      chk("ld_addr",      {20'b0, mem_addr}, 32'd8);
      push(1'b1, 1'b1, 32'h1122_BEEF);
      tick();
      d_req = 1'b0;
      tick();

      // Back-to-back fetches.
      i_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         i_addr = 32'h50 + 32'(4 * k);
         #1;
         chk("b2b_i_gnt",  {31'b0, i_gnt}, 32'd1);
         chk("b2b_addr",   {20'b0, mem_addr}, 32'(20 + k));
         push(1'b0, 1'b1, 32'hA000_0014 + 32'(k));
         tick();
      end
      i_req = 1'b0;
      tick();

      // Continuous loads against a waiting fetch.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      i_req = 1'b1; i_addr = 32'h200;
      w = 0;
      for (int c = 1; c <= 10; c++) begin
         #1;
`ifdef ARB_STARVE_GUARD_EN
         exp_i = (w >= MAX_WAIT);
         w = exp_i ? 0 : w + 1;
`else
         exp_i = 1'b0;
`endif
         chk("starve_i_gnt", {31'b0, i_gnt}, {31'b0, exp_i});
         chk("starve_d_gnt", {31'b0, d_gnt}, {31'b0, !exp_i});
         if (exp_i) push(1'b0, 1'b1, 32'hA000_0080);
         else       push(1'b1, 1'b1, 32'hA000_0040);
         tick();
      end
      i_req = 1'b0; d_req = 1'b0;
      tick();

      // Reset arriving while a load's data is due back.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      #1;
      chk("mid_d_gnt", {31'b0, d_gnt}, 32'd1);
      @(posedge clk);
      #1;
      d_req = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_d_rvalid", {31'b0, d_rvalid}, 32'd0);
      chk("mid_d_rdata",  d_rdata, 32'd0);
      chk("mid_mem_en",   {31'b0, mem_en}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
